// File: rtl/game_uart_tx.sv
// Game-state UART transmitter: sends a 3-byte packet {cmd, score[11:8], score[7:0]} as 8N1 frames, LSB first.
// Define GAME_UART_TX_PARITY_EN to add an even-parity bit to each frame, giving 8E1 framing.
module game_uart_tx #(
    parameter int CLK_FREQ = 40000000,
    parameter int BAUD     = 9600
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        send,
    input  logic [7:0]  cmd,
    input  logic [11:0] score,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int DIV_RAW = CLK_FREQ / BAUD;
    localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
    localparam int BW      = $clog2(DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    localparam logic [BW-1:0] BAUD_ZERO = BW'(0);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef GAME_UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

`ifdef GAME_UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`endif

    state_t          state_r, state_s;
    logic [BW-1:0]   baud_r, baud_s;
    logic [2:0]      bit_r, bit_s;
    logic [1:0]      idx_r, idx_s;
    logic [7:0]      shift_r, shift_s;
    logic [3:0]      hi_r, hi_s;
    logic [7:0]      lo_r, lo_s;
    logic            tx_r, tx_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;
    logic            last_s;
`ifdef GAME_UART_TX_PARITY_EN
    logic            par_r, par_s;
`endif

    // Next-state, datapath and next-output logic; outputs are registered from the next state.
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r;
        bit_s   = bit_r;
        idx_s   = idx_r;
        shift_s = shift_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        done_s  = 1'b0;
        tx_s    = 1'b1;
        busy_s  = 1'b0;
        last_s  = (baud_r == BAUD_LAST);
`ifdef GAME_UART_TX_PARITY_EN
        par_s   = par_r;
`endif

        case (state_r)
            S_IDLE: begin
                if (send) begin
                    state_s = S_START;
                    baud_s  = BAUD_ZERO;
                    bit_s   = 3'd0;
                    idx_s   = 2'd0;
                    shift_s = cmd;
                    hi_s    = score[11:8];
                    lo_s    = score[7:0];
`ifdef GAME_UART_TX_PARITY_EN
                    par_s   = even_parity(cmd);
`endif
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                if (last_s) begin
                    state_s = S_DATA;
                    baud_s  = BAUD_ZERO;
                    bit_s   = 3'd0;
                end else begin
                    baud_s  = baud_r + BAUD_ONE;
                end
            end
            S_DATA: begin
                if (last_s) begin
                    baud_s = BAUD_ZERO;
                    if (bit_r == 3'd7) begin
`ifdef GAME_UART_TX_PARITY_EN
                        state_s = S_PARITY;
`else
                        state_s = S_STOP;
`endif
                    end else begin
                        bit_s   = bit_r + 3'd1;
                        shift_s = {1'b0, shift_r[7:1]};
                    end
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
`ifdef GAME_UART_TX_PARITY_EN
            S_PARITY: begin
                if (last_s) begin
                    state_s = S_STOP;
                    baud_s  = BAUD_ZERO;
                end else begin
                    baud_s  = baud_r + BAUD_ONE;
                end
            end
`endif
            S_STOP: begin
                if (last_s) begin
                    baud_s = BAUD_ZERO;
                    if (idx_r < 2'd2) begin
                        // Chain straight into the next start bit so bytes leave with no idle gap.
                        state_s = S_START;
                        idx_s   = idx_r + 2'd1;
                        if (idx_r == 2'd0) begin
                            shift_s = {4'h0, hi_r};
                        end else begin
                            shift_s = lo_r;
                        end
`ifdef GAME_UART_TX_PARITY_EN
                        par_s = even_parity(shift_s);
`endif
                    end else begin
                        state_s = S_IDLE;
                        done_s  = 1'b1;
                    end
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            default: begin
                state_s = S_IDLE;
                baud_s  = BAUD_ZERO;
                bit_s   = 3'd0;
                idx_s   = 2'd0;
            end
        endcase

        case (state_s)
            S_IDLE:   tx_s = 1'b1;
            S_START:  tx_s = 1'b0;
            S_DATA:   tx_s = shift_s[0];
`ifdef GAME_UART_TX_PARITY_EN
            S_PARITY: tx_s = par_s;
`endif
            S_STOP:   tx_s = 1'b1;
            default:  tx_s = 1'b1;
        endcase

        busy_s = (state_s != S_IDLE);
    end

    // State, counters, packet holding registers and registered line outputs.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            baud_r  <= BAUD_ZERO;
            bit_r   <= 3'd0;
            idx_r   <= 2'd0;
            shift_r <= 8'h00;
            hi_r    <= 4'h0;
            lo_r    <= 8'h00;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef GAME_UART_TX_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            idx_r   <= idx_s;
            shift_r <= shift_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
            tx_r    <= tx_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
`ifdef GAME_UART_TX_PARITY_EN
            par_r   <= par_s;
`endif
        end
    end

    assign tx   = tx_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_game_uart_tx.sv
// Directed bench for game_uart_tx at DIV=16; follows GAME_UART_TX_PARITY_EN for frame length.
module tb_game_uart_tx;

    localparam int DIV = 16;
`ifdef GAME_UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int PKT = 3 * FB * DIV;

    logic        pclk;
    logic        rst;
    logic        send;
    logic [7:0]  cmd;
    logic [11:0] score;
    logic        tx;
    logic        busy;
    logic        done;

    int n_tests;
    int n_fail;

    game_uart_tx #(
        .CLK_FREQ(40000000),
        .BAUD    (2500000)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .send (send),
        .cmd  (cmd),
        .score(score),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Expected line level k cycles after the accept edge (k=1 is the first start-bit cycle).
    function automatic logic exp_tx(input logic [7:0] b0, input logic [7:0] b1,
                                    input logic [7:0] b2, input logic [2:0] par, input int k);
        int bitpos;
        int byt;
        int b;
        logic [7:0] d;
        logic r;
        bitpos = (k - 1) / DIV;
        byt    = bitpos / FB;
        b      = bitpos % FB;
        case (byt)
            0:       d = b0;
            1:       d = b1;
            default: d = b2;
        endcase
        if (k < 1 || k > PKT)  r = 1'b1;
        else if (b == 0)       r = 1'b0;
        else if (b <= 8)       r = d[b-1];
`ifdef GAME_UART_TX_PARITY_EN
        else if (b == 9)       r = par[byt];
`endif
        else                   r = 1'b1;
        return r;
    endfunction

    task automatic start_send(input logic [7:0] c, input logic [11:0] s);
        send  = 1'b1;
        cmd   = c;
        score = s;
    endtask

    task automatic test_reset;
        int bad;
        rst = 1'b1; send = 1'b0; cmd = 8'h00; score = 12'h000;
        repeat (5) @(negedge pclk);
        n_tests++; if (tx !== 1'b1)   begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        rst = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge pclk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL idle_line: %0d bad cycles, want 0", bad); end
    endtask

    task automatic test_single_packet;
        int ln_err, bsy_err, dn_err, first_bad;
        ln_err = 0; bsy_err = 0; dn_err = 0; first_bad = -1;
        @(negedge pclk);
        start_send(8'hA5, 12'h3C7);
        for (int k = 1; k <= PKT; k++) begin
            @(negedge pclk);
            if (k == 1) begin
                n_tests++;
                if (tx !== 1'b0 || busy !== 1'b1) begin
                    n_fail++; $display("FAIL single_latency: tx=%b busy=%b want tx=0 busy=1", tx, busy);
                end
                send = 1'b0;
            end
            if (tx !== exp_tx(8'hA5, 8'h03, 8'hC7, 3'b100, k)) begin
                ln_err++; if (first_bad < 0) first_bad = k;
            end
            if (busy !== 1'b1) bsy_err++;
            if (done !== 1'b0) dn_err++;
        end
        n_tests++; if (ln_err !== 0)  begin n_fail++; $display("FAIL single_line: %0d bad cycles (first E+%0d), want 0", ln_err, first_bad); end
        n_tests++; if (bsy_err !== 0) begin n_fail++; $display("FAIL single_busy: %0d low cycles, want 0", bsy_err); end
        n_tests++; if (dn_err !== 0)  begin n_fail++; $display("FAIL single_early_done: %0d cycles, want 0", dn_err); end
        @(negedge pclk);
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
            n_fail++; $display("FAIL single_done: done=%b busy=%b tx=%b want 1 0 1 at E+%0d", done, busy, tx, PKT + 1);
        end
        @(negedge pclk);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_width: done=%b want 0", done); end
    endtask

    task automatic test_ignored_request;
        int ln_err, dn_cnt, idle_err;
        ln_err = 0; dn_cnt = 0; idle_err = 0;
        @(negedge pclk);
        start_send(8'hA5, 12'h3C7);
        for (int k = 1; k <= PKT + 120; k++) begin
            @(negedge pclk);
            if (k == 1)  send = 1'b0;
            if (k == 99) start_send(8'h02, 12'hFFF);
            if (k == 100) send = 1'b0;
            if (tx !== exp_tx(8'hA5, 8'h03, 8'hC7, 3'b100, k)) ln_err++;
            if (done === 1'b1) dn_cnt++;
            if (k > PKT && busy !== 1'b0) idle_err++;
        end
        n_tests++; if (ln_err !== 0)   begin n_fail++; $display("FAIL ignored_line: %0d bad cycles, want 0", ln_err); end
        n_tests++; if (dn_cnt !== 1)   begin n_fail++; $display("FAIL ignored_done_count: got %0d want 1", dn_cnt); end
        n_tests++; if (idle_err !== 0) begin n_fail++; $display("FAIL ignored_second_packet: %0d busy cycles, want 0", idle_err); end
    endtask

    task automatic test_back_to_back;
        int ln_err;
        ln_err = 0;
        @(negedge pclk);
        start_send(8'hA5, 12'h3C7);
        for (int k = 1; k <= PKT; k++) begin
            @(negedge pclk);
            if (k == 1) send = 1'b0;
        end
        @(negedge pclk);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b want 1", done); end
        start_send(8'h03, 12'h001);
        for (int k = 1; k <= PKT; k++) begin
            @(negedge pclk);
            if (k == 1) begin
                n_tests++;
                if (tx !== 1'b0 || busy !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_gap: tx=%b busy=%b want tx=0 busy=1", tx, busy);
                end
                send = 1'b0;
            end
            if (tx !== exp_tx(8'h03, 8'h00, 8'h01, 3'b100, k)) ln_err++;
        end
        n_tests++; if (ln_err !== 0) begin n_fail++; $display("FAIL b2b_line: %0d bad cycles, want 0", ln_err); end
        @(negedge pclk);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done: got %b want 1", done); end
    endtask

    task automatic test_reset_mid_packet;
        int ln_err, idle_err, dn_err;
        ln_err = 0; idle_err = 0; dn_err = 0;
        @(negedge pclk);
        start_send(8'h5A, 12'h000);
        for (int k = 1; k <= 200; k++) begin
            @(negedge pclk);
            if (k == 1) send = 1'b0;
            if (tx !== exp_tx(8'h5A, 8'h00, 8'h00, 3'b000, k)) ln_err++;
        end
        n_tests++; if (ln_err !== 0) begin n_fail++; $display("FAIL midrst_line: %0d bad cycles, want 0", ln_err); end
        rst = 1'b1;
        #1;
        n_tests++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL midrst_async: tx=%b busy=%b done=%b want 1 0 0", tx, busy, done);
        end
        repeat (3) begin
            @(negedge pclk);
            if (done !== 1'b0) dn_err++;
        end
        rst = 1'b0;
        repeat (50) begin
            @(negedge pclk);
            if (tx !== 1'b1 || busy !== 1'b0) idle_err++;
            if (done !== 1'b0) dn_err++;
        end
        n_tests++; if (idle_err !== 0) begin n_fail++; $display("FAIL midrst_idle: %0d bad cycles, want 0", idle_err); end
        n_tests++; if (dn_err !== 0)   begin n_fail++; $display("FAIL midrst_done: %0d done cycles, want 0", dn_err); end
        ln_err = 0;
        start_send(8'hA5, 12'h3C7);
        for (int k = 1; k <= PKT; k++) begin
            @(negedge pclk);
            if (k == 1) send = 1'b0;
            if (tx !== exp_tx(8'hA5, 8'h03, 8'hC7, 3'b100, k) || busy !== 1'b1) ln_err++;
        end
        n_tests++; if (ln_err !== 0) begin n_fail++; $display("FAIL midrst_fresh_line: %0d bad cycles, want 0", ln_err); end
        @(negedge pclk);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL midrst_fresh_done: got %b want 1", done); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset;
        test_single_packet;
        test_ignored_request;
        test_back_to_back;
        test_reset_mid_packet;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/game_uart_tx.md
Name: game_uart_tx

Overview:
UART transmitter that sends the local game state to the opposing board. It is the transmit end of the serial link whose receive end produces uart_start. The block is driven by the top-level game FSM on pclk. On a send strobe it serialises a fixed 3-byte packet (command, score high, score low) as 8N1 frames, LSB first, on a single tx line.

Parameters:
CLK_FREQ, 40000000, pclk frequency in Hz
BAUD, 9600, line rate in bit/s; bit period DIV = CLK_FREQ/BAUD (integer truncation), minimum 2

Ports:
pclk  input  1  system clock
rst  input  1  asynchronous, active-high reset
send  input  1  one-cycle request strobe; sampled only when busy=0
cmd  input  8  command byte (e.g. 8'h01 START, 8'h02 STOP, 8'h03 SCORE)
score  input  12  score value sent with the packet
tx  output  1  serial line, idle high
busy  output  1  packet in progress
done  output  1  one-cycle pulse at end of the packet

Behaviour:
- Clock and reset: one clock (pclk). Reset is asynchronous and active-high (rst).
- Reset values: tx=1, busy=0, done=0, FSM=IDLE, all counters 0. Reset asserted mid-packet aborts immediately: tx returns high asynchronously and no done pulse is generated.
- Capture: on the pclk edge where send=1 and busy=0, latch byte0=cmd, byte1={4'b0,score[11:8]}, byte2=score[7:0]. A send arriving while busy=1 is ignored and not queued.
- Latency: from the accept edge E, busy=1 and tx=0 (start bit) are both visible at E+1.
- FSM states:
  - IDLE: tx=1. Go to START on accept.
  - START: tx=0 for DIV cycles, then DATA.
  - DATA: tx=shift[0] for DIV cycles per bit; bits 0..7, LSB first. After bit 7 go to PARITY if enabled, else STOP.
  - PARITY: see Optional Feature.
  - STOP: tx=1 for DIV cycles. If byte index<2, increment the index, load the next byte and go to START with no idle gap. Otherwise go to IDLE.
- Baud counter: runs 0..DIV-1 and restarts on every state entry, so every bit lasts exactly DIV cycles. There is no cumulative drift within a packet.
- Packet length: 30*DIV cycles (33*DIV with parity), measured from E+1.
- Completion: on the cycle after the final stop bit ends, busy=0 and done=1 for exactly one cycle. A send in that cycle is accepted, giving back-to-back packets separated by zero idle bits.
- Glitch-free output: tx is driven from a register.
- Counter widths: the bit counter is 3 bits, the byte index is 2 bits, and the baud counter is clog2(DIV) bits.

Optional Feature:
- Macro: GAME_UART_TX_PARITY_EN.
- Defined: each byte carries an even-parity bit between bit 7 and the stop bit. The PARITY state drives tx = XOR of the 8 data bits for DIV cycles, and the packet is 33*DIV cycles long.
- Undefined: the PARITY state and its logic are not compiled in, giving 8N1 framing and 30*DIV-cycle packets.

Test Plan:
- Reset check (CLK_FREQ=40000000, BAUD=2500000, DIV=16): hold rst for 5 cycles -> tx=1, busy=0, done=0. Idle for 100 cycles -> tx stays 1.
- Single packet: send with cmd=8'hA5, score=12'h3C7 -> tx=0 at E+1 for 16 cycles. Bytes on the line are A5, 03, C7, LSB first (A5 bits 1,0,1,0,0,1,0,1). busy high for 480 cycles. done=1 exactly once at E+481.
- Ignored request: pulse send with cmd=8'h02 at E+100 during a packet -> line content unchanged (still A5/03/C7), a single done pulse, and no second packet.
- Back-to-back: assert send with cmd=8'h03, score=12'h001 in the done cycle -> the next start bit begins on the following cycle with no idle bits. Second packet is 03, 00, 01.
- Reset mid-packet: assert rst at E+200 -> tx=1 and busy=0 immediately, no done pulse. A fresh send after release transmits a full, correct packet.
- With GAME_UART_TX_PARITY_EN: same stimulus as the single-packet test -> parity bits are 0, 0, 1 for A5, 03, C7. busy lasts 528 cycles; done at E+529.
